irq_ctrl: RTL and testbench

- Memory-mapped interrupt controller directly upstream of the CPU core's 6-bit interrupt input.
- Synchronises six asynchronous peripheral request lines and latches them as edge- or level-triggered pending bits.
- Applies a software mask and drives the core's INT[5:0] from a registered output.
- Sits on the core's data-memory bus (address = alu_out, write data = wd_dm, write enable = we_dm). Its read data is muxed into rd_dm when sel is high.

---
 rtl/irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_irq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller feeding the core's INT[5:0].
//
// Six asynchronous request lines are synchronised, latched as edge- or
// level-triggered pending bits, masked, and presented to the core through
// a registered output. Software sees a 32-byte register window on the
// data-memory bus.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   irq_in  raw peripheral requests (asynchronous to clk)
//   addr    byte address from the core (alu_out)
//   wd      write data from the core (wd_dm)
//   we      write strobe from the core (we_dm)
//   rd      read data, combinational from addr, zero when not selected
//   sel     high when addr falls inside the register window
//   INT     registered interrupt requests (PEND & MASK)
//
// Register map (byte offset, addr[1:0] ignored):
//   0x00 PEND   read pending; write-1-to-clear (edge-mode bits only)
//   0x04 MASK   r/w, 1 = enabled
//   0x08 EDGE   r/w, 1 = edge mode, 0 = level mode
//   0x0C STATUS bit31 = any enabled pending, [2:0] = highest enabled index
//   0x10 LOST   8-bit saturating count of overrun edges; any write clears
//   0x14-0x1C   read 0, writes ignored
module irq_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0800,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  irq_in,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd,
    output logic        sel,
    output logic [5:0]  INT
);

    localparam logic [2:0] OFF_PEND   = 3'd0;
    localparam logic [2:0] OFF_MASK   = 3'd1;
    localparam logic [2:0] OFF_EDGE   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_LOST   = 3'd4;

    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic [5:0] prev_q, prev_d;
    logic [5:0] pend_q, pend_d;
    logic [5:0] mask_q, mask_d;
    logic [5:0] edge_q, edge_d;
    logic [7:0] lost_q, lost_d;
    logic [5:0] int_q, int_d;

    logic [2:0]  off;
    logic        wr;
    logic [5:0]  s;
    logic [5:0]  rise;
    logic [5:0]  w1c;
    logic [5:0]  lost_ev;
    logic [2:0]  lost_inc;
    logic [8:0]  lost_sum;
    logic [5:0]  pm;
    logic [2:0]  pm_idx;
    logic [31:0] status;

    // Bus bits that carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wd[31:6]};

    assign sel  = (addr[31:5] == BASE_ADDR[31:5]);
    assign off  = addr[4:2];
    assign wr   = we & sel;
    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign w1c  = (wr && off == OFF_PEND) ? wd[5:0] : 6'h00;
    assign pm   = pend_q & mask_q;
    assign INT  = int_q;

    always_comb begin
        pm_idx = 3'd0;
        // Ascending scan: the last hit is the highest-numbered bit.
        for (int i = 0; i < 6; i++) begin
            if (pm[i]) pm_idx = 3'(i);
        end
        status = {|pm, 28'h0, pm_idx};
    end

    always_comb begin
        rd = 32'h0;
        if (sel) begin
            case (off)
                OFF_PEND:   rd = {26'h0, pend_q};
                OFF_MASK:   rd = {26'h0, mask_q};
                OFF_EDGE:   rd = {26'h0, edge_q};
                OFF_STATUS: rd = status;
                OFF_LOST:   rd = {24'h0, lost_q};
                default:    rd = 32'h0;
            endcase
        end
    end

    always_comb begin
        if (SYNC_STAGES > 1) sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        else                 sync_d = irq_in;
        prev_d = s;

        // Edge mode: a new edge beats a simultaneous clear. Level mode: follow s.
        for (int i = 0; i < 6; i++) begin
            if (edge_q[i]) pend_d[i] = rise[i] | (pend_q[i] & ~w1c[i]);
            else           pend_d[i] = s[i];
        end

        // An edge arriving on a bit still pending (and not being cleared) is lost.
        lost_ev  = edge_q & rise & pend_q & ~w1c;
        lost_inc = 3'd0;
        for (int i = 0; i < 6; i++) begin
            lost_inc = lost_inc + {2'b00, lost_ev[i]};
        end
        lost_sum = {1'b0, lost_q} + {6'h00, lost_inc};

        if (wr && off == OFF_LOST) lost_d = 8'h00;
        else if (lost_sum[8])      lost_d = 8'hFF;
        else                       lost_d = lost_sum[7:0];

        mask_d = (wr && off == OFF_MASK) ? wd[5:0] : mask_q;
        edge_d = (wr && off == OFF_EDGE) ? wd[5:0] : edge_q;
        int_d  = pm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 6'h00;
            pend_q <= 6'h00;
            mask_q <= 6'h00;
            edge_q <= 6'h3F;
            lost_q <= 8'h00;
            int_q  <= 6'h00;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            lost_q <= lost_d;
            int_q  <= int_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl. Inputs change 1 ns after the
// rising edge; outputs are sampled there as well, away from the edge.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq_in;
    logic [31:0] addr, wd;
    logic        we;
    logic [31:0] rd;
    logic        sel;
    logic [5:0]  int_o;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(.BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .addr(addr), .wd(wd),
        .we(we), .rd(rd), .sel(sel), .INT(int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        addr = BASE + off;
        #1;
        chk(tag, rd, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        step();
        we   = 1'b0;
    endtask

    task automatic pulse(input int b, input int hi, input int lo);
        irq_in[b] = 1'b1;
        repeat (hi) step();
        irq_in[b] = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        rst = 1'b1; irq_in = 6'h00; addr = 32'h0; wd = 32'h0; we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("int_in_reset", {26'h0, int_o}, 32'h0);
        rst = 1'b0;
        step();

        // Reset values of every register
        rd_chk("rst_pend",   32'h00, 32'h0);
        rd_chk("rst_mask",   32'h04, 32'h0);
        rd_chk("rst_edge",   32'h08, 32'h3F);
        rd_chk("rst_status", 32'h0C, 32'h0);
        rd_chk("rst_lost",   32'h10, 32'h0);
        rd_chk("rst_res14",  32'h14, 32'h0);
        chk("rst_int", {26'h0, int_o}, 32'h0);
        chk("sel_in_window", {31'h0, sel}, 32'h1);

        // Edge capture latency on irq_in[2]
        wr(BASE + 32'h04, 32'h3F);
        irq_in[2] = 1'b1;                       // before edge k
        step(); rd_chk("lat_pend_k",  32'h00, 32'h0);
        step(); rd_chk("lat_pend_k1", 32'h00, 32'h0);
        step(); rd_chk("lat_pend_k2", 32'h00, 32'h04);
        chk("lat_int_k2", {26'h0, int_o}, 32'h0);
        irq_in[2] = 1'b0;
        step(); chk("lat_int_k3", {26'h0, int_o}, 32'h04);
        rd_chk("status_bit2", 32'h0C, 32'h8000_0002);

        // W1C at edge j -> INT drops after edge j+1
        wr(BASE + 32'h00, 32'h04);
        chk("w1c_int_j", {26'h0, int_o}, 32'h04);
        rd_chk("w1c_pend_j", 32'h00, 32'h0);
        step(); chk("w1c_int_j1", {26'h0, int_o}, 32'h0);

        // Re-arm INT = 0x04, then reset asynchronously mid-cycle
        irq_in[2] = 1'b1;
        repeat (2) step();
        irq_in[2] = 1'b0;
        repeat (2) step();
        chk("rearm_int", {26'h0, int_o}, 32'h04);
        #1 rst = 1'b1;
        #1 chk("async_rst_int", {26'h0, int_o}, 32'h0);
        rd_chk("async_rst_pend", 32'h00, 32'h0);
        rd_chk("async_rst_mask", 32'h04, 32'h0);
        step();
        rst = 1'b0;
        step();

        // LOST counting and saturation on irq_in[1]
        wr(BASE + 32'h04, 32'h3F);
        pulse(1, 2, 2);
        pulse(1, 2, 2);
        repeat (4) step();
        rd_chk("lost_one",  32'h10, 32'h1);
        rd_chk("lost_pend", 32'h00, 32'h02);
        for (int n = 0; n < 300; n++) pulse(1, 2, 2);
        repeat (4) step();
        rd_chk("lost_sat", 32'h10, 32'hFF);
        wr(BASE + 32'h10, 32'h1234);
        rd_chk("lost_clear", 32'h10, 32'h0);

        // Same-cycle edge and W1C on bit 3: set wins, no LOST bump
        pulse(3, 2, 2);
        repeat (4) step();
        rd_chk("b3_pend_set", 32'h00, 32'h0A);
        irq_in[3] = 1'b1;                       // before edge k
        step();
        step();
        wr(BASE + 32'h00, 32'h08);              // lands on edge k+2 with the rise
        rd_chk("b3_race_pend", 32'h00, 32'h0A);
        rd_chk("b3_race_lost", 32'h10, 32'h0);
        irq_in[3] = 1'b0;
        repeat (4) step();
        wr(BASE + 32'h00, 32'h08);
        rd_chk("b3_w1c_alone", 32'h00, 32'h02);
        rd_chk("b3_lost_still0", 32'h10, 32'h0);

        // Level mode on bit 0
        wr(BASE + 32'h08, 32'h3E);
        irq_in[0] = 1'b1;
        repeat (4) step();
        rd_chk("lvl_pend", 32'h00, 32'h03);
        wr(BASE + 32'h00, 32'h01);
        rd_chk("lvl_w1c_j", 32'h00, 32'h03);
        step();
        rd_chk("lvl_w1c_j1", 32'h00, 32'h03);
        irq_in[0] = 1'b0;                       // before edge k
        step(); rd_chk("lvl_drop_k",  32'h00, 32'h03);
        step(); rd_chk("lvl_drop_k1", 32'h00, 32'h03);
        step(); rd_chk("lvl_drop_k2", 32'h00, 32'h02);

        // Masking and priority with PEND = 0x23
        wr(BASE + 32'h08, 32'h3F);
        pulse(0, 2, 2);
        pulse(5, 2, 2);
        repeat (4) step();
        rd_chk("prio_pend", 32'h00, 32'h23);
        wr(BASE + 32'h04, 32'h21);
        chk("mask_int_j", {26'h0, int_o}, 32'h23);
        step();
        chk("mask_int_j1", {26'h0, int_o}, 32'h21);
        rd_chk("prio_status", 32'h0C, 32'h8000_0005);

        // Outside the window
        addr = 32'h0000_0900;
        #1;
        chk("out_sel", {31'h0, sel}, 32'h0);
        chk("out_rd", rd, 32'h0);
        addr = BASE + 32'h1F;
        #1;
        chk("edge_sel_1f", {31'h0, sel}, 32'h1);
        wr(32'h0000_0904, 32'h0);
        wr(32'h0000_0900, 32'h23);
        wr(32'h0000_0908, 32'h0);
        wr(BASE + 32'h14, 32'hFFFF_FFFF);
        rd_chk("out_mask",  32'h04, 32'h21);
        rd_chk("out_pend",  32'h00, 32'h23);
        rd_chk("out_edge",  32'h08, 32'h3F);
        rd_chk("res14_rd",  32'h14, 32'h0);
        chk("out_int", {26'h0, int_o}, 32'h21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
